// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory responder: small program buffer streamed out one word per ack
// Each word is delivered after LATENCY wait cycles, driven by the initiator's syn level.
module imem_responder #(
  parameter int IWIDTH  = 32,
  parameter int DEPTH   = 5,
  parameter int LATENCY = 1,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_i_syn,
  input  logic              r_i_restart,
  input  logic              r_i_wr_en,
  input  logic [AW-1:0]     r_i_wr_addr,
  input  logic [IWIDTH-1:0] r_i_wr_data,
  output logic [IWIDTH-1:0] r_o_instr,
  output logic              r_o_last,
  output logic              r_o_ack,
  output logic              r_o_busy,
  output logic              r_o_done
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

  localparam logic [3:0]    LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [IWIDTH-1:0] mem [DEPTH];
  state_t            state, state_n;
  logic [AW-1:0]     ptr, ptr_n;
  logic [3:0]        cnt, cnt_n;

  // Buffer has no reset so a program survives r_rst.
  always_ff @(posedge r_clk) begin
    if (r_i_wr_en && (int'(r_i_wr_addr) < DEPTH)) begin
      mem[r_i_wr_addr] <= r_i_wr_data;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    if (r_i_restart) begin
      state_n = IDLE;
      ptr_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (r_i_syn) begin
            if (LATENCY == 0) begin
              state_n = ACK;
            end else begin
              state_n = WAIT;
              cnt_n   = LAT_M1;
            end
          end
        end
        WAIT: begin
          if (!r_i_syn) begin
            state_n = IDLE;
          end else if (cnt == 4'd0) begin
            state_n = ACK;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
        ACK: begin
          // The beat is consumed regardless of syn during the ack cycle.
          ptr_n = ptr + AW'(1);
          if (ptr == LAST_IDX) begin
            state_n = DONE;
          end else if (r_i_syn) begin
            if (LATENCY == 0) begin
              state_n = ACK;
            end else begin
              state_n = WAIT;
              cnt_n   = LAT_M1;
            end
          end else begin
            state_n = IDLE;
          end
        end
        DONE: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so the buffer is read at the
  // edge entering ACK and a same-edge write is not yet visible.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      r_o_instr <= '0;
      r_o_ack   <= 1'b0;
      r_o_last  <= 1'b0;
      r_o_busy  <= 1'b0;
      r_o_done  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      r_o_ack  <= (state_n == ACK);
      r_o_last <= (state_n == ACK) && (ptr_n == LAST_IDX);
      r_o_busy <= (state_n == WAIT) || (state_n == ACK);
      r_o_done <= (state_n == DONE);
      if (state_n == ACK) begin
        r_o_instr <= mem[ptr_n];
      end
    end
  end

endmodule
